jkt_mode_register: RTL and testbench
====================================

// Module: jkt_mode_register
// PURPOSE
//   WIDTH-bit multi-mode storage register. Every bit is a T flip-flop; a per-mode
//   excitation function turns it into a JK, T, D or SR register, or a synchronous up/down counter.
//   Used as the common bit-bank for control/status registers and small event counters
//   in the sequential-primitives library.
// PARAMETERS
//   WIDTH    8   register width in bits (>=2)
//   RST_VAL  0   value loaded into q on reset (WIDTH bits)
// PORTS
//   clk     in   1      clock, rising edge
//   rst     in   1      reset, asynchronous, active-high
//   en      in   1      clock enable; 0 = hold everything, no pulses
//   mode    in   3      operating mode (encoding below)
//   j       in   WIDTH  J / T / D / S data, per bit, by mode
//   k       in   WIDTH  K / R data, per bit, by mode
//   q       out  WIDTH  register state
//   qb      out  WIDTH  ~q, combinational
//   wrap    out  1      registered 1-cycle pulse: counter wrapped (or saturated, see CONFIGURATION)
//   sr_err  out  1      registered 1-cycle pulse: SR conflict detected
// BEHAVIOUR
//   Reset: q=RST_VAL, wrap=0, sr_err=0. Async assert; release is sync to clk.
//   All state is updated only on posedge clk with en=1. Latency is 1 cycle: inputs sampled at edge N appear on q after edge N.
//   Per bit i: q[i] <= q[i] ^ t[i]. The t vector depends on mode:
//     0 HOLD : t=0
//     1 JK   : t = (j & ~q) | (k & q)   (J=K=1 toggles, J=K=0 holds)
//     2 T    : t = j
//     3 D    : t = j ^ q                (q loads j)
//     4 UP   : t[0]=1, t[i]=&q[i-1:0]   (q+1 mod 2^WIDTH)
//     5 DOWN : t[0]=1, t[i]=&~q[i-1:0]  (q-1 mod 2^WIDTH)
//     6 SR   : t = (j & ~k & ~q) | (k & ~j & q); bits with j=k=1 hold
//     7 rsvd : behaves as HOLD
//   Counter modes (4 and 5) ignore j and k.
//   wrap: pulses for one cycle after the edge where UP moved FF..F->0 or DOWN moved 0->FF..F.
//     It is 0 on every other cycle, including when en=0.
//   sr_err: pulses for one cycle after an enabled SR-mode edge with |(j&k)=1.
//     Non-conflicting bits still update on that edge.
//   A mode change takes effect on the same edge. There is no pipeline state, so a mode
//     switch mid-count simply continues from the current q.
//   rst asserted mid-operation: q returns to RST_VAL immediately and any pending
//     wrap/sr_err pulse is cleared.
// CONFIGURATION
//   JKT_SAT_EN defined:
//     UP holds at all-ones and DOWN holds at zero.
//     wrap pulses on each enabled edge where the count is held at the limit.
//   JKT_SAT_EN undefined: modulo wrap as above.
//   Other modes are unaffected by JKT_SAT_EN.
// STRUCTURE
//   Package jkt_pkg holds:
//     - mode localparams: MODE_HOLD, MODE_JK, MODE_T, MODE_D, MODE_UP, MODE_DOWN, MODE_SR
//     - function t_excite(mode, j, k, q, carry) returning 1 bit
//   Sub-module jkt_cell: one T flip-flop with inputs clk, rst, en, t, rst_val and output q.
//     It is instantiated WIDTH times by a generate loop.
//   The top level holds:
//     - the carry/borrow chains
//     - saturation detection
//     - the wrap and sr_err flops
// TESTING
//   1 Reset mid-count, RST_VAL=8'h5A:
//     UP for 3 clocks, then pulse rst between edges -> q=5A at once, wrap=0, sr_err=0.
//   2 JK mode, q=00:
//     j=F0,k=00 -> q=F0; then j=FF,k=FF -> q=0F; then j=00,k=0F -> q=00.
//   3 UP wrap (WIDTH=8), q=FE:
//     2 edges -> q=FF then 00; wrap=1 for exactly the cycle after the 00 edge.
//     DOWN from 00 -> FF with wrap=1.
//     With JKT_SAT_EN: UP holds at FF, wrap=1 every edge; DOWN holds at 00.
//   4 SR mode, q=0F:
//     j=F0,k=0F -> q=F0, sr_err=0.
//     Then j=03,k=01 -> q=F2, sr_err=1 for 1 cycle.
//   5 D/T and en gating:
//     D mode j=A5 -> q=A5. T mode j=FF -> q=5A.
//     en=0 with mode=UP for 4 edges -> q stays 5A, wrap=0.
//   6 Mode 7 and mode switching:
//     mode=7 -> hold. UP from 10 for 2 edges, then DOWN for 1 edge -> q=11.

Source files
------------

// File: rtl/jkt_pkg.sv
// Shared mode encodings and per-bit excitation function for the multi-mode T-flip-flop register.
package jkt_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_JK   = 3'd1;
  localparam logic [2:0] MODE_T    = 3'd2;
  localparam logic [2:0] MODE_D    = 3'd3;
  localparam logic [2:0] MODE_UP   = 3'd4;
  localparam logic [2:0] MODE_DOWN = 3'd5;
  localparam logic [2:0] MODE_SR   = 3'd6;

  // Toggle request for one bit; carry is the up/down chain term for that bit (1 for bit 0).
  function automatic logic t_excite(
    input logic [2:0] mode,
    input logic       j,
    input logic       k,
    input logic       q,
    input logic       carry
  );
    logic t;
    t = 1'b0;
    case (mode)
      MODE_JK:   t = (j & ~q) | (k & q);
      MODE_T:    t = j;
      MODE_D:    t = j ^ q;
      MODE_UP:   t = carry;
      MODE_DOWN: t = carry;
      MODE_SR:   t = (j & ~k & ~q) | (k & ~j & q);
      default:   t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/jkt_cell.sv
// Single T flip-flop with per-instance reset value and clock enable.
module jkt_cell (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic t,
  input  logic rst_val,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= rst_val;
    end else if (en) begin
      q <= q ^ t;
    end
  end

endmodule

// File: rtl/jkt_mode_register.sv
// WIDTH-bit multi-mode register (JK/T/D/SR/up/down counter) built from T flip-flops.
// Optional macro JKT_SAT_EN: counters saturate at the limits instead of wrapping.
module jkt_mode_register
  import jkt_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             wrap,
  output logic             sr_err
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_up_chain;
  logic [WIDTH-1:0] w_dn_chain;
  logic [WIDTH-1:0] w_carry;
  logic             w_limit;
  logic             w_sat_hold;
  logic             w_conflict;
  logic             r_wrap;
  logic             r_sr_err;

  // Counter sits at the edge of its range: the next step would wrap (or is held when saturating).
  assign w_limit = ((mode == MODE_UP) && (&w_q)) || ((mode == MODE_DOWN) && (~|w_q));

`ifdef JKT_SAT_EN
  assign w_sat_hold = w_limit;
`else
  assign w_sat_hold = 1'b0;
`endif

  assign w_conflict    = (mode == MODE_SR) && (|(j & k));
  assign w_up_chain[0] = 1'b1;
  assign w_dn_chain[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_chain
      assign w_up_chain[gi] = w_up_chain[gi-1] & w_q[gi-1];
      assign w_dn_chain[gi] = w_dn_chain[gi-1] & ~w_q[gi-1];
    end

    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign w_carry[gi] = (mode == MODE_DOWN) ? w_dn_chain[gi] : w_up_chain[gi];
      assign w_t[gi]     = ~w_sat_hold & t_excite(mode, j[gi], k[gi], w_q[gi], w_carry[gi]);

      jkt_cell u_cell (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .t       (w_t[gi]),
        .rst_val (RST_VAL[gi]),
        .q       (w_q[gi])
      );
    end
  endgenerate

  // Pulse flops are rewritten every cycle so en=0 forces them low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap   <= 1'b0;
      r_sr_err <= 1'b0;
    end else begin
      r_wrap   <= en & w_limit;
      r_sr_err <= en & w_conflict;
    end
  end

  assign q      = w_q;
  assign qb     = ~w_q;
  assign wrap   = r_wrap;
  assign sr_err = r_sr_err;

endmodule

// File: tb/tb_jkt_mode_register.sv
// Self-checking bench for jkt_mode_register: directed table, reset corner sequences, random vs. model.
module tb_jkt_mode_register;

`ifdef JKT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [2:0] mode = 3'd0;
  logic [7:0] j = 8'h00;
  logic [7:0] k = 8'h00;
  logic [7:0] q, qb;
  logic       wrap, sr_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       en;
    logic [2:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] q;
    logic       wrap;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  logic [7:0] m_q;
  logic       m_wrap, m_err;

  jkt_mode_register #(.WIDTH(8), .RST_VAL(8'h5A)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .j      (j),
    .k      (k),
    .q      (q),
    .qb     (qb),
    .wrap   (wrap),
    .sr_err (sr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] eq, input logic ew, input logic ee);
    check({tag, ".q"}, q, eq);
    check({tag, ".qb"}, qb, ~eq);
    check({tag, ".wrap"}, {7'd0, wrap}, {7'd0, ew});
    check({tag, ".sr_err"}, {7'd0, sr_err}, {7'd0, ee});
  endtask

  task automatic apply(input logic e, input logic [2:0] m, input logic [7:0] jj, input logic [7:0] kk);
    @(negedge clk);
    en = e; mode = m; j = jj; k = kk;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic e, input logic [2:0] m, input logic [7:0] jj, input logic [7:0] kk,
                     input logic [7:0] eq, input logic ew, input logic ee);
    vec_t v;
    v.en = e; v.mode = m; v.j = jj; v.k = kk; v.q = eq; v.wrap = ew; v.err = ee;
    vecs.push_back(v);
  endtask

  // Reference behaviour from the mode truth tables and plain arithmetic.
  task automatic model_step(input logic e, input logic [2:0] m, input logic [7:0] jj, input logic [7:0] kk);
    logic [7:0] nq;
    m_wrap = 1'b0;
    m_err  = 1'b0;
    if (!e) return;
    nq = m_q;
    case (m)
      3'd1: for (int i = 0; i < 8; i++) begin
        if (jj[i] && !kk[i]) nq[i] = 1'b1;
        else if (!jj[i] && kk[i]) nq[i] = 1'b0;
        else if (jj[i] && kk[i]) nq[i] = ~m_q[i];
      end
      3'd2: nq = m_q ^ jj;
      3'd3: nq = jj;
      3'd4: begin
        m_wrap = (m_q == 8'd255);
        nq = (SAT && m_wrap) ? m_q : 8'(m_q + 8'd1);
      end
      3'd5: begin
        m_wrap = (m_q == 8'd0);
        nq = (SAT && m_wrap) ? m_q : 8'(m_q - 8'd1);
      end
      3'd6: begin
        m_err = |(jj & kk);
        nq = (m_q | (jj & ~kk)) & ~(kk & ~jj);
      end
      default: nq = m_q;
    endcase
    m_q = nq;
  endtask

  initial begin
    // Reset state
    #12;
    check_all("reset", 8'h5A, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset mid-count clears q and a pending wrap pulse
    for (int i = 0; i < 3; i++) apply(1'b1, 3'd4, 8'h00, 8'h00);
    check("up3.q", q, 8'h5D);
    apply(1'b1, 3'd3, 8'hFF, 8'h00);
    apply(1'b1, 3'd4, 8'h00, 8'h00);
    check("prewrap.wrap", {7'd0, wrap}, 8'h01);
    rst = 1'b1;
    #1;
    check_all("midrst", 8'h5A, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset clears a pending sr_err pulse
    apply(1'b1, 3'd6, 8'h01, 8'h01);
    check("preerr.sr_err", {7'd0, sr_err}, 8'h01);
    rst = 1'b1;
    #1;
    check_all("errrst", 8'h5A, 1'b0, 1'b0);
    rst = 1'b0;

    // Directed table, starting from q=5A
    add(1, 3'd3, 8'h00, 8'h00, 8'h00, 0, 0);
    add(1, 3'd1, 8'hF0, 8'h00, 8'hF0, 0, 0);
    add(1, 3'd1, 8'hFF, 8'hFF, 8'h0F, 0, 0);
    add(1, 3'd1, 8'h00, 8'h0F, 8'h00, 0, 0);
    add(1, 3'd3, 8'hFE, 8'h00, 8'hFE, 0, 0);
    add(1, 3'd4, 8'h00, 8'h00, 8'hFF, 0, 0);
    if (SAT) begin
      add(1, 3'd4, 8'h00, 8'h00, 8'hFF, 1, 0);
      add(1, 3'd4, 8'hAA, 8'h55, 8'hFF, 1, 0);
    end else begin
      add(1, 3'd4, 8'h00, 8'h00, 8'h00, 1, 0);
      add(1, 3'd4, 8'hAA, 8'h55, 8'h01, 0, 0);
    end
    add(1, 3'd3, 8'h00, 8'h00, 8'h00, 0, 0);
    if (SAT) begin
      add(1, 3'd5, 8'h00, 8'h00, 8'h00, 1, 0);
      add(1, 3'd5, 8'h00, 8'h00, 8'h00, 1, 0);
    end else begin
      add(1, 3'd5, 8'h00, 8'h00, 8'hFF, 1, 0);
      add(1, 3'd5, 8'h00, 8'h00, 8'hFE, 0, 0);
    end
    add(1, 3'd3, 8'hFF, 8'h00, 8'hFF, 0, 0);
    add(0, 3'd4, 8'h00, 8'h00, 8'hFF, 0, 0);
    add(1, 3'd3, 8'h0F, 8'h00, 8'h0F, 0, 0);
    add(1, 3'd6, 8'hF0, 8'h0F, 8'hF0, 0, 0);
    add(1, 3'd6, 8'h03, 8'h01, 8'hF2, 0, 1);
    add(1, 3'd0, 8'hFF, 8'hFF, 8'hF2, 0, 0);
    add(0, 3'd6, 8'hFF, 8'hFF, 8'hF2, 0, 0);
    add(1, 3'd3, 8'hA5, 8'h00, 8'hA5, 0, 0);
    add(1, 3'd2, 8'hFF, 8'h00, 8'h5A, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 3'd4, 8'h00, 8'h00, 8'h5A, 0, 0);
    add(1, 3'd7, 8'hFF, 8'hFF, 8'h5A, 0, 0);
    add(1, 3'd3, 8'h10, 8'h00, 8'h10, 0, 0);
    add(1, 3'd4, 8'h00, 8'h00, 8'h11, 0, 0);
    add(1, 3'd4, 8'h00, 8'h00, 8'h12, 0, 0);
    add(1, 3'd5, 8'h00, 8'h00, 8'h11, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].mode, vecs[i].j, vecs[i].k);
      check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].wrap, vecs[i].err);
    end

    // Random stimulus against the reference model
    m_q = vecs[vecs.size()-1].q;
    for (int n = 0; n < 400; n++) begin
      logic       e;
      logic [2:0] m;
      logic [7:0] jj, kk;
      e  = ($urandom_range(0, 7) != 0);
      m  = 3'($urandom_range(0, 7));
      jj = 8'($urandom);
      kk = 8'($urandom);
      if ($urandom_range(0, 9) == 0) jj = 8'hFF;
      apply(e, m, jj, kk);
      model_step(e, m, jj, kk);
      check_all($sformatf("rnd%0d", n), m_q, m_wrap, m_err);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
